// File: rtl/axis_frame_len_adjust.sv
// Byte-wide AXI4-Stream frame length normaliser: zero-pads short frames to MIN_LEN,
// truncates long frames at MAX_LEN (flagged bad via tuser) and reports one status record per frame.
module axis_frame_len_adjust #(
    parameter int LEN_WIDTH = 16,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 status_valid,
    output logic [LEN_WIDTH-1:0] status_frame_len,
    output logic                 status_padded,
    output logic                 status_truncated
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_PAD    = 2'd1,
        ST_TRUNC  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH:0]   MIN_L        = (LEN_WIDTH+1)'(MIN_LEN);
    localparam logic [LEN_WIDTH:0]   MAX_L        = (LEN_WIDTH+1)'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] CNT_ALL_ONES = '1;

    // Saturating increment for the input beat counter.
    function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
        sat_inc = (v == CNT_ALL_ONES) ? v : v + LEN_WIDTH'(1);
    endfunction

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   out_cnt_q, out_cnt_d;
    logic [LEN_WIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic                   pad_user_q, pad_user_d;
    logic [7:0]             m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic                   m_user_q, m_user_d;
    logic                   st_valid_q, st_valid_d;
    logic [LEN_WIDTH-1:0]   st_len_q, st_len_d;
    logic                   st_pad_q, st_pad_d;
    logic                   st_trunc_q, st_trunc_d;
    logic                   load_s;
    logic                   s_ready_s;
    logic [LEN_WIDTH:0]     out_nxt_s;

    assign load_s    = m_axis_tready || !m_valid_q;
    assign out_nxt_s = {1'b0, out_cnt_q} + (LEN_WIDTH+1)'(1);

    // Next-state, output-register and status computation.
    always_comb begin
        state_d    = state_q;
        out_cnt_d  = out_cnt_q;
        in_cnt_d   = in_cnt_q;
        pad_user_d = pad_user_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_user_d   = m_user_q;
        st_valid_d = 1'b0;
        st_len_d   = st_len_q;
        st_pad_d   = st_pad_q;
        st_trunc_d = st_trunc_q;
        s_ready_s  = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                s_ready_s = load_s;
                if (s_axis_tvalid && load_s) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_tdata;
                    out_cnt_d = out_nxt_s[LEN_WIDTH-1:0];
                    in_cnt_d  = sat_inc(in_cnt_q);
                    if (s_axis_tlast) begin
                        if (out_nxt_s >= MIN_L) begin
                            m_last_d   = 1'b1;
                            m_user_d   = s_axis_tuser;
                            st_valid_d = 1'b1;
                            st_len_d   = sat_inc(in_cnt_q);
                            st_pad_d   = 1'b0;
                            st_trunc_d = 1'b0;
                            out_cnt_d  = '0;
                            in_cnt_d   = '0;
                        end else begin
                            m_last_d   = 1'b0;
                            m_user_d   = 1'b0;
                            pad_user_d = s_axis_tuser;
                            state_d    = ST_PAD;
                        end
                    end else if (out_nxt_s == MAX_L) begin
                        m_last_d = 1'b1;
                        m_user_d = 1'b1;
                        state_d  = ST_TRUNC;
                    end else begin
                        m_last_d = 1'b0;
                        m_user_d = 1'b0;
                    end
                end else if (load_s) begin
                    m_valid_d = 1'b0;
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
            ST_PAD: begin
                s_ready_s = 1'b0;
                if (load_s) begin
                    m_valid_d = 1'b1;
                    m_data_d  = 8'h00;
                    out_cnt_d = out_nxt_s[LEN_WIDTH-1:0];
                    if (out_nxt_s == MIN_L) begin
                        m_last_d   = 1'b1;
                        m_user_d   = pad_user_q;
                        st_valid_d = 1'b1;
                        st_len_d   = in_cnt_q;
                        st_pad_d   = 1'b1;
                        st_trunc_d = 1'b0;
                        out_cnt_d  = '0;
                        in_cnt_d   = '0;
                        state_d    = ST_ACTIVE;
                    end else begin
                        m_last_d = 1'b0;
                        m_user_d = 1'b0;
                    end
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
            ST_TRUNC: begin
                // Input is swallowed; the output register only drains the truncated last beat.
                s_ready_s = 1'b1;
                if (load_s) begin
                    m_valid_d = 1'b0;
                end else begin
                    m_valid_d = m_valid_q;
                end
                if (s_axis_tvalid) begin
                    in_cnt_d = sat_inc(in_cnt_q);
                    if (s_axis_tlast) begin
                        st_valid_d = 1'b1;
                        st_len_d   = sat_inc(in_cnt_q);
                        st_pad_d   = 1'b0;
                        st_trunc_d = 1'b1;
                        out_cnt_d  = '0;
                        in_cnt_d   = '0;
                        state_d    = ST_ACTIVE;
                    end else begin
                        state_d = ST_TRUNC;
                    end
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // State, counter, output and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_ACTIVE;
            out_cnt_q  <= '0;
            in_cnt_q   <= '0;
            pad_user_q <= 1'b0;
            m_data_q   <= 8'h00;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_user_q   <= 1'b0;
            st_valid_q <= 1'b0;
            st_len_q   <= '0;
            st_pad_q   <= 1'b0;
            st_trunc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            in_cnt_q   <= in_cnt_d;
            pad_user_q <= pad_user_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_user_q   <= m_user_d;
            st_valid_q <= st_valid_d;
            st_len_q   <= st_len_d;
            st_pad_q   <= st_pad_d;
            st_trunc_q <= st_trunc_d;
        end
    end

    // Ready is forced low while reset is held so the upstream sees no acceptance.
    assign s_axis_tready    = rst & s_ready_s;
    assign m_axis_tdata     = m_data_q;
    assign m_axis_tvalid    = m_valid_q;
    assign m_axis_tlast     = m_last_q;
    assign m_axis_tuser     = m_user_q;
    assign status_valid     = st_valid_q;
    assign status_frame_len = st_len_q;
    assign status_padded    = st_pad_q;
    assign status_truncated = st_trunc_q;

endmodule

// File: tb/tb_axis_frame_len_adjust.sv
// Randomized directed bench for axis_frame_len_adjust: a default-parameter instance and a
// narrow-counter instance, both checked against a frame-level reference model.
module tb_axis_frame_len_adjust;

    logic       clk;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tuser;
    logic       m_tready;
    logic       sel;
    int         rdy_mode;
    int         vectors;
    int         fails;

    logic [7:0]  a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast, a_tuser, b_tuser;
    logic        a_sready, b_sready, a_svalid, b_svalid;
    logic        a_pad, b_pad, a_trunc, b_trunc;
    logic [15:0] a_slen;
    logic [7:0]  b_slen;

    logic [7:0]  o_tdata;
    logic        o_tvalid, o_tlast, o_tuser, o_sready, o_svalid, o_pad, o_trunc;
    logic [15:0] o_slen;

    logic [7:0]  fr[$];
    logic [9:0]  out_q[$];
    logic [9:0]  exp_q[$];
    logic [17:0] st_q[$];
    logic [17:0] exp_st_q[$];

    axis_frame_len_adjust u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_sready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
        .status_valid(a_svalid), .status_frame_len(a_slen),
        .status_padded(a_pad), .status_truncated(a_trunc)
    );

    axis_frame_len_adjust #(.LEN_WIDTH(8), .MIN_LEN(64), .MAX_LEN(200)) u_dut_sat (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_sready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
        .status_valid(b_svalid), .status_frame_len(b_slen),
        .status_padded(b_pad), .status_truncated(b_trunc)
    );

    assign o_tdata  = sel ? b_tdata  : a_tdata;
    assign o_tvalid = sel ? b_tvalid : a_tvalid;
    assign o_tlast  = sel ? b_tlast  : a_tlast;
    assign o_tuser  = sel ? b_tuser  : a_tuser;
    assign o_sready = sel ? b_sready : a_sready;
    assign o_svalid = sel ? b_svalid : a_svalid;
    assign o_slen   = sel ? {8'h00, b_slen} : a_slen;
    assign o_pad    = sel ? b_pad    : a_pad;
    assign o_trunc  = sel ? b_trunc  : a_trunc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collects every output handshake and status pulse of the selected instance.
    always @(posedge clk) begin
        if (rst && o_tvalid && m_tready) out_q.push_back({o_tdata, o_tlast, o_tuser});
        if (rst && o_svalid) st_q.push_back({o_slen, o_pad, o_trunc});
    end

    logic       stall_p;
    logic [10:0] held;
    // Output must not change while a valid beat is stalled.
    always @(posedge clk) begin
        if (rst && stall_p) chk("stall_hold", {o_tvalid, o_tdata, o_tlast, o_tuser}, held);
        stall_p <= rst && o_tvalid && !m_tready;
        held    <= {o_tvalid, o_tdata, o_tlast, o_tuser};
    end

    task automatic step();
        @(negedge clk);
        case (rdy_mode)
            1:       m_tready = 1'($urandom_range(0, 1));
            2:       m_tready = 1'b0;
            default: m_tready = 1'b1;
        endcase
    endtask

    // Frame-level reference: clamp the length into [MIN, MAX], pad with zeros, flag truncation.
    task automatic model(input bit user);
        int minl = 64;
        int maxl = sel ? 200 : 1518;
        int satv = sel ? 255 : 65535;
        int len  = fr.size();
        int outl = (len < minl) ? minl : ((len > maxl) ? maxl : len);
        int slen = (len > satv) ? satv : len;
        for (int i = 0; i < outl; i++) begin
            logic [7:0] d = (i < len) ? fr[i] : 8'h00;
            logic       l = (i == outl - 1);
            logic       u = l ? ((len > maxl) ? 1'b1 : user) : 1'b0;
            exp_q.push_back({d, l, u});
        end
        exp_st_q.push_back({16'(slen), 1'(len < minl), 1'(len > maxl)});
    endtask

    task automatic send(input bit user, input bit with_last);
        for (int i = 0; i < fr.size(); i++) begin
            int n = 0;
            step();
            s_tvalid = 1'b1;
            s_tdata  = fr[i];
            s_tlast  = with_last && (i == fr.size() - 1);
            s_tuser  = s_tlast ? user : 1'($urandom_range(0, 1));
            #1;
            while (!o_sready && n < 1000) begin
                step();
                #1;
                n++;
            end
            chk("s_tready_wait", o_sready, 1'b1);
        end
    endtask

    task automatic frame(input int len, input bit user, input bit ramp);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(ramp ? 8'(i + 1) : 8'($urandom));
        model(user);
        send(user, 1'b1);
    endtask

    task automatic drain_and_check(input string tag);
        int n = 0;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        while ((out_q.size() < exp_q.size() || st_q.size() < exp_st_q.size()) && n < 10000) begin
            step();
            n++;
        end
        repeat (5) step();
        chk({tag, "_beat_count"}, out_q.size(), exp_q.size());
        chk({tag, "_status_count"}, st_q.size(), exp_st_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), out_q[i][9:1], exp_q[i][9:1]);
            if (exp_q[i][1]) chk($sformatf("%s_tuser%0d", tag, i), out_q[i][0], exp_q[i][0]);
        end
        for (int i = 0; i < st_q.size() && i < exp_st_q.size(); i++)
            chk($sformatf("%s_status%0d", tag, i), st_q[i], exp_st_q[i]);
        out_q.delete(); exp_q.delete(); st_q.delete(); exp_st_q.delete();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        out_q.delete(); st_q.delete();
    endtask

    initial begin
        vectors  = 0;
        fails    = 0;
        sel      = 1'b0;
        rdy_mode = 0;
        rst      = 1'b0;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_tvalid, o_tdata, o_tlast, o_tuser, o_sready, o_svalid, o_slen, o_pad, o_trunc}, 64'h0);
        rst = 1'b1;

        // Asynchronous reset while a beat is held in the output register.
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'($urandom));
        send(1'b0, 1'b0);
        rdy_mode = 2;
        step();
        s_tvalid = 1'b0;
        chk("pre_reset_tvalid", o_tvalid, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {o_tvalid, o_tdata, o_tlast, o_tuser, o_sready, o_svalid, o_slen, o_pad, o_trunc}, 64'h0);
        repeat (2) step();
        rst = 1'b1;
        rdy_mode = 0;
        out_q.delete(); st_q.delete();

        frame(64, 1'b0, 1'b0);
        drain_and_check("post_reset_64");
        frame(10, 1'b1, 1'b1);
        drain_and_check("pad_10");
        frame(2000, 1'b0, 1'b0);
        drain_and_check("trunc_2000");
        frame(1518, 1'b0, 1'b0);
        drain_and_check("exact_1518");
        frame(64, 1'b1, 1'b0);
        drain_and_check("exact_64");
        frame(1, 1'b0, 1'b0);
        frame(63, 1'b1, 1'b0);
        frame(65, 1'b1, 1'b0);
        drain_and_check("short_b2b");

        rdy_mode = 1;
        frame(5, 1'($urandom_range(0, 1)), 1'b0);
        frame(100, 1'($urandom_range(0, 1)), 1'b0);
        frame(1600, 1'($urandom_range(0, 1)), 1'b0);
        drain_and_check("backpressure");
        rdy_mode = 0;

        sel = 1'b1;
        do_reset();
        frame(300, 1'b0, 1'b0);
        drain_and_check("saturate_300");
        frame(200, 1'b0, 1'b0);
        drain_and_check("sat_exact_200");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/axis_frame_len_adjust.md
# axis_frame_len_adjust

Byte-wide AXI4-Stream frame length normaliser. It sits directly upstream of `axis_fifo` and feeds its `s_axis` port. Frames shorter than `MIN_LEN` beats are zero-padded, and frames longer than `MAX_LEN` beats are truncated and flagged bad via `tuser`, so a downstream FIFO in frame mode can drop them. Each frame produces one status record with its original length.

## Interface
- `LEN_WIDTH`, 16: width of the length counters and of `status_frame_len`.
- `MIN_LEN`, 64: minimum output frame length in beats. 0 disables padding. Constraint: `MIN_LEN <= MAX_LEN`.
- `MAX_LEN`, 1518: maximum output frame length in beats. Constraints: ≥1 and < 2^LEN_WIDTH.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous active-low reset (asserted when 0); deassertion is synchronised externally.
- `s_axis_tdata`  in  8  input data.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tlast`  in  1  input end of frame.
- `s_axis_tuser`  in  1  input bad-frame flag; sampled on the `tlast` beat.
- `m_axis_tdata`  out  8  output data.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tlast`  out  1  output end of frame.
- `m_axis_tuser`  out  1  output bad-frame flag; meaningful on the `tlast` beat only.
- `status_valid`  out  1  one-cycle pulse per completed frame.
- `status_frame_len`  out  LEN_WIDTH  original input beat count; saturates at all-ones.
- `status_padded`  out  1  frame was padded.
- `status_truncated`  out  1  frame was truncated.

## Operation
- **Output register:** single stage (`m_axis_*` registers). It may load when `m_axis_tready || !m_axis_tvalid`; this condition is called `load`.
- **Counters:**
  - `out_cnt` counts beats emitted in the current frame.
  - `in_cnt` counts beats accepted and saturates at 2^LEN_WIDTH−1.
  - Both clear when a frame completes.
- **State ACTIVE** (reset state):
  - `s_axis_tready = load`.
  - On an accepted beat, the beat is loaded into the output register and `out_cnt` increments.
  - Accepted `tlast` with `out_cnt+1 >= MIN_LEN`: output `tlast=1`, `tuser = s_axis_tuser`. Frame completes (padded=0, truncated=0).
  - Accepted `tlast` with `out_cnt+1 < MIN_LEN`: output `tlast=0`. Latch `s_axis_tuser` into `pad_user`. Go to PAD.
  - Accepted non-last beat with `out_cnt+1 == MAX_LEN`: output `tlast=1`, `tuser=1`. Go to TRUNC.
  - If `tlast` arrives on the beat where `out_cnt+1 == MAX_LEN`, the frame is exact-length and the `tlast` rule applies, so there is no truncation.
- **State PAD:**
  - `s_axis_tready = 0`.
  - On each `load`, emit `tdata = 0x00`.
  - The beat where `out_cnt+1 == MIN_LEN` carries `tlast=1` and `tuser = pad_user`. Frame completes (padded=1). Return to ACTIVE.
- **State TRUNC:**
  - `s_axis_tready = 1`; all beats are discarded and `in_cnt` keeps counting.
  - Accepted `tlast`: frame completes (truncated=1). Return to ACTIVE.
- **Status:**
  - On frame completion, the status fields are registered and `status_valid` pulses for exactly one cycle.
  - `status_frame_len` is the original input length, including the `tlast` beat.
- **Reset:**
  - All outputs go to 0 (`m_axis_tvalid`, `tdata`, `tlast`, `tuser`, `s_axis_tready`, all status). State returns to ACTIVE and the counters clear.
  - Reset mid-frame abandons the frame without emitting a status record.
- **After reset:** the first accepted beat starts a new frame.

## Timing
- Latency: an input beat accepted at edge N is valid on `m_axis` after edge N (one register stage).
- Throughput: one beat per cycle in ACTIVE when `m_axis_tready=1`. PAD emits one beat per cycle.
- `s_axis_tready` is combinational from `m_axis_tready`, `m_axis_tvalid` and state only; no dependency on `s_axis_tvalid`.
- Output stalls: `m_axis_*` hold stable while `m_axis_tvalid && !m_axis_tready`.
- `status_valid` timing: asserts the cycle after the completing event:
  - accept of the final input beat (ACTIVE, TRUNC), or
  - load of the final pad beat (PAD).
- Back-to-back frames: the next frame's first beat may be accepted in the cycle immediately after an ACTIVE or TRUNC completion. After PAD, it may be accepted in the cycle following the final pad load.
- A one-beat frame with `MIN_LEN ≤ 1` completes in one accept cycle.

## Test plan
- **Reset:** drive `rst=0` mid-frame with `m_axis_tvalid=1` → all outputs 0 asynchronously. After release, a 64-beat frame passes unchanged and status reports len=64, padded=0, truncated=0.
- **Padding:** MIN_LEN=64; send a 10-beat frame 0x01..0x0A with `tuser=1` on last → 64 output beats: 0x01..0x0A then 54×0x00, `tlast` on beat 64, `tuser=1`. Status reports len=10, padded=1.
- **Truncation:** MAX_LEN=1518; send a 2000-beat frame → 1518 output beats, `tlast=1` and `tuser=1` on beat 1518. Remaining 482 beats are accepted and dropped. Status reports len=2000, truncated=1.
- **Exact boundaries:**
  - 1518-beat frame → `tuser` equals the input value, truncated=0.
  - 64-beat frame → padded=0.
- **Backpressure:** random `m_axis_tready` (50%) with back-to-back 5-, 100- and 1600-beat frames → output sequence bit-exact to the model, no beat lost or duplicated, held data stable during stalls, exactly 3 status pulses in order.
- **Saturation:** LEN_WIDTH=8, MAX_LEN=200; send a 300-beat frame → `status_frame_len=255`, truncated=1.
